// File: rtl/md_pkg.sv
// Shared types and helpers for the MD iteration control path.
package md_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        FORCE,
        DRAIN,
        MU,
        FINISH
    } iter_state_t;

    // Widest per-node vector popcount accepts; narrower vectors are zero-extended by the caller.
    localparam int POPCNT_MAX_W = 256;
    localparam int POPCNT_OUT_W = $clog2(POPCNT_MAX_W + 1);

    function automatic logic [POPCNT_OUT_W-1:0] popcount(input logic [POPCNT_MAX_W-1:0] v);
        logic [POPCNT_OUT_W-1:0] n;
        n = '0;
        for (int i = 0; i < POPCNT_MAX_W; i++) begin
            n = n + POPCNT_OUT_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/iteration_sequencer_inflight_counter.sv
// Tracks ring packets in flight: injected minus delivered per cycle, saturating, sticky error.
module inflight_counter
    import md_pkg::*;
#(
    parameter int NUM_CELLS      = 64,
    parameter int INFLIGHT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CELLS-1:0]      i_pkt_injected,
    input  logic [NUM_CELLS-1:0]      i_pkt_delivered,
    output logic [INFLIGHT_WIDTH-1:0] o_count,
    output logic                      o_overflow_err
);

    localparam int SW = INFLIGHT_WIDTH + POPCNT_OUT_W + 1;
    localparam logic signed [SW-1:0] CNT_MAX_S = {{(SW-INFLIGHT_WIDTH){1'b0}}, {INFLIGHT_WIDTH{1'b1}}};

    logic [INFLIGHT_WIDTH-1:0] r_count;
    logic                      r_overflow_err;
    logic [POPCNT_OUT_W-1:0]   w_pop_inj;
    logic [POPCNT_OUT_W-1:0]   w_pop_del;
    logic signed [SW-1:0]      w_delta;
    logic signed [SW-1:0]      w_next;
    logic [INFLIGHT_WIDTH-1:0] w_sat_val;
    logic                      w_sat_ovf;

    // Clamp to [0, all-ones]; MSB of the result flags that clamping happened.
    function automatic logic [INFLIGHT_WIDTH:0] saturate(input logic signed [SW-1:0] v);
        if (v[SW-1]) begin
            return {1'b1, {INFLIGHT_WIDTH{1'b0}}};
        end else if (v > CNT_MAX_S) begin
            return {1'b1, {INFLIGHT_WIDTH{1'b1}}};
        end else begin
            return {1'b0, v[INFLIGHT_WIDTH-1:0]};
        end
    endfunction

    assign w_pop_inj = popcount(POPCNT_MAX_W'(i_pkt_injected));
    assign w_pop_del = popcount(POPCNT_MAX_W'(i_pkt_delivered));
    assign w_delta   = $signed(SW'(w_pop_inj)) - $signed(SW'(w_pop_del));
    assign w_next    = $signed(SW'(r_count)) + w_delta;
    assign {w_sat_ovf, w_sat_val} = saturate(w_next);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count        <= '0;
            r_overflow_err <= 1'b0;
        end else begin
            r_count        <= w_sat_val;
            r_overflow_err <= r_overflow_err | w_sat_ovf;
        end
    end

    assign o_count        = r_count;
    assign o_overflow_err = r_overflow_err;

endmodule

// File: rtl/iteration_sequencer.sv
// Sequences force / drain / motion-update phases for num_iter MD iterations.
// Optional ITER_SEQ_PERF_CNT_EN adds force_cycles / drain_cycles counters.
module iteration_sequencer
    import md_pkg::*;
#(
    parameter int NUM_CELLS      = 64,
    parameter int ITER_WIDTH     = 16,
    parameter int INFLIGHT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ITER_WIDTH-1:0] num_iter,
    input  logic [NUM_CELLS-1:0]  ref_wb_issued,
    input  logic                  goto_next_ref,
    input  logic [NUM_CELLS-1:0]  pkt_injected,
    input  logic [NUM_CELLS-1:0]  pkt_delivered,
    input  logic                  all_reading_done,
    input  logic                  all_filter_buffer_empty,
    input  logic                  force_cache_input_buffer_empty,
    input  logic                  mu_done,
    output logic                  iter_start,
    output logic                  all_ref_wb_issued,
    output logic                  interconnect_empty,
    output logic                  motion_update_start,
    output logic [ITER_WIDTH-1:0] iter_count,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow_err
`ifdef ITER_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]           force_cycles,
    output logic [31:0]           drain_cycles
`endif
);

    iter_state_t               r_state;
    logic [ITER_WIDTH-1:0]     r_num_iter;
    logic [ITER_WIDTH-1:0]     r_iter_count;
    logic                      r_iter_start;
    logic                      r_mu_start;
    logic                      r_done;
    logic                      r_busy;
    logic [NUM_CELLS-1:0]      r_capture;
    logic                      r_all_ref;
    logic [INFLIGHT_WIDTH-1:0] w_inflight_count;
    logic                      w_overflow_err;
    logic                      w_ic_empty;
    logic                      w_drain_ok;
    logic [ITER_WIDTH-1:0]     w_iter_next;

    inflight_counter #(
        .NUM_CELLS      (NUM_CELLS),
        .INFLIGHT_WIDTH (INFLIGHT_WIDTH)
    ) u_inflight (
        .clk             (clk),
        .rst             (rst),
        .i_pkt_injected  (pkt_injected),
        .i_pkt_delivered (pkt_delivered),
        .o_count         (w_inflight_count),
        .o_overflow_err  (w_overflow_err)
    );

    assign w_ic_empty  = (w_inflight_count == '0);
    assign w_iter_next = r_iter_count + ITER_WIDTH'(1);
    // A packet accepted this cycle is not yet visible in the counter, so it must block the drain exit.
    assign w_drain_ok  = w_ic_empty && all_filter_buffer_empty &&
                         force_cache_input_buffer_empty && (pkt_injected == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_num_iter   <= '0;
            r_iter_count <= '0;
            r_iter_start <= 1'b0;
            r_mu_start   <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_iter_start <= 1'b0;
            r_mu_start   <= 1'b0;
            r_done       <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_iter_count <= '0;
                        if (num_iter != '0) begin
                            r_num_iter   <= num_iter;
                            r_state      <= LAUNCH;
                            r_iter_start <= 1'b1;
                            r_busy       <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                LAUNCH: r_state <= FORCE;
                FORCE: begin
                    if (all_reading_done) r_state <= DRAIN;
                end
                DRAIN: begin
                    if (w_drain_ok) begin
                        r_state    <= MU;
                        r_mu_start <= 1'b1;
                    end
                end
                MU: begin
                    if (mu_done) begin
                        r_iter_count <= w_iter_next;
                        if (w_iter_next == r_num_iter) begin
                            r_state <= FINISH;
                            r_done  <= 1'b1;
                        end else begin
                            r_state      <= LAUNCH;
                            r_iter_start <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Clear takes priority over OR-in so a bit arriving with goto_next_ref belongs to the next reference.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_capture <= '0;
            r_all_ref <= 1'b0;
        end else if (goto_next_ref) begin
            r_capture <= (r_state == FORCE) ? ref_wb_issued : '0;
            r_all_ref <= 1'b0;
        end else begin
            if (r_state == FORCE) r_capture <= r_capture | ref_wb_issued;
            if (&r_capture) r_all_ref <= 1'b1;
        end
    end

`ifdef ITER_SEQ_PERF_CNT_EN
    logic [31:0] r_force_cycles;
    logic [31:0] r_drain_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_force_cycles <= '0;
            r_drain_cycles <= '0;
        end else if (r_state == IDLE && start) begin
            r_force_cycles <= '0;
            r_drain_cycles <= '0;
        end else begin
            if (r_state == FORCE && r_force_cycles != '1) r_force_cycles <= r_force_cycles + 32'd1;
            if (r_state == DRAIN && r_drain_cycles != '1) r_drain_cycles <= r_drain_cycles + 32'd1;
        end
    end

    assign force_cycles = r_force_cycles;
    assign drain_cycles = r_drain_cycles;
`endif

    assign iter_start          = r_iter_start;
    assign all_ref_wb_issued   = r_all_ref;
    assign interconnect_empty  = w_ic_empty;
    assign motion_update_start = r_mu_start;
    assign iter_count          = r_iter_count;
    assign busy                = r_busy;
    assign done                = r_done;
    assign overflow_err        = w_overflow_err;

endmodule

// File: tb/tb_iteration_sequencer.sv
// Directed + randomized bench for iteration_sequencer (NUM_CELLS=4, 4-bit in-flight counter).
module tb_iteration_sequencer;

    localparam int NC  = 4;
    localparam int IW  = 8;
    localparam int FW  = 4;
    localparam int CMX = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [IW-1:0] num_iter;
    logic [NC-1:0] ref_wb_issued;
    logic          goto_next_ref;
    logic [NC-1:0] pkt_injected;
    logic [NC-1:0] pkt_delivered;
    logic          all_reading_done;
    logic          all_filter_buffer_empty;
    logic          force_cache_input_buffer_empty;
    logic          mu_done;
    logic          iter_start;
    logic          all_ref_wb_issued;
    logic          interconnect_empty;
    logic          motion_update_start;
    logic [IW-1:0] iter_count;
    logic          busy;
    logic          done;
    logic          overflow_err;
`ifdef ITER_SEQ_PERF_CNT_EN
    logic [31:0]   force_cycles;
    logic [31:0]   drain_cycles;
`endif

    iteration_sequencer #(
        .NUM_CELLS      (NC),
        .ITER_WIDTH     (IW),
        .INFLIGHT_WIDTH (FW)
    ) dut (
        .clk                            (clk),
        .rst                            (rst),
        .start                          (start),
        .num_iter                       (num_iter),
        .ref_wb_issued                  (ref_wb_issued),
        .goto_next_ref                  (goto_next_ref),
        .pkt_injected                   (pkt_injected),
        .pkt_delivered                  (pkt_delivered),
        .all_reading_done               (all_reading_done),
        .all_filter_buffer_empty        (all_filter_buffer_empty),
        .force_cache_input_buffer_empty (force_cache_input_buffer_empty),
        .mu_done                        (mu_done),
`ifdef ITER_SEQ_PERF_CNT_EN
        .force_cycles                   (force_cycles),
        .drain_cycles                   (drain_cycles),
`endif
        .iter_start                     (iter_start),
        .all_ref_wb_issued              (all_ref_wb_issued),
        .interconnect_empty             (interconnect_empty),
        .motion_update_start            (motion_update_start),
        .iter_count                     (iter_count),
        .busy                           (busy),
        .done                           (done),
        .overflow_err                   (overflow_err)
    );

    always #5 clk = ~clk;

    int        checks   = 0;
    int        failures = 0;
    int        m_cnt    = 0;
    bit        m_ovf    = 1'b0;
    logic [3:0] m_cap   = 4'h0;
    bit        m_flag   = 1'b0;
    bit        m_force  = 1'b0;
    bit        m_drain  = 1'b0;
    int        m_fc     = 0;
    int        m_dc     = 0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock: update the reference model from the inputs presented this cycle, then check.
    task automatic tick();
        int nxt;
        if (rst) begin
            m_cnt = 0; m_ovf = 1'b0; m_cap = 4'h0; m_flag = 1'b0; m_fc = 0; m_dc = 0;
        end else begin
            nxt = m_cnt + $countones(pkt_injected) - $countones(pkt_delivered);
            if (nxt < 0) begin
                nxt = 0; m_ovf = 1'b1;
            end else if (nxt > CMX) begin
                nxt = CMX; m_ovf = 1'b1;
            end
            m_cnt = nxt;
            if (goto_next_ref) begin
                m_flag = 1'b0;
                m_cap  = m_force ? ref_wb_issued : 4'h0;
            end else begin
                if (m_cap == 4'hF) m_flag = 1'b1;
                if (m_force) m_cap = m_cap | ref_wb_issued;
            end
            if (m_force) m_fc++;
            if (m_drain) m_dc++;
        end
        @(posedge clk);
        #1;
        chkn("inflight_count", 32'(dut.w_inflight_count), 32'(m_cnt));
        chk1("overflow_err", overflow_err, m_ovf);
        chk1("interconnect_empty", interconnect_empty, m_cnt == 0);
        chk1("all_ref_wb_issued", all_ref_wb_issued, m_flag);
    endtask

    task automatic start_run(input int n);
        num_iter = IW'(n);
        start    = 1'b1;
        m_fc = 0; m_dc = 0;
        tick();
        start = 1'b0;
        if (n != 0) begin
            chk1("launch_iter_start", iter_start, 1'b1);
            chk1("launch_busy", busy, 1'b1);
            chk1("launch_done", done, 1'b0);
            chkn("launch_iter_count", 32'(iter_count), 32'd0);
        end else begin
            chk1("zero_done", done, 1'b1);
            chk1("zero_iter_start", iter_start, 1'b0);
            chk1("zero_busy", busy, 1'b0);
            tick();
            chk1("zero_done_pulse", done, 1'b0);
            chk1("zero_iter_start2", iter_start, 1'b0);
        end
    endtask

    task automatic enter_force();
        tick();
        chk1("force_iter_start_low", iter_start, 1'b0);
        chk1("force_busy", busy, 1'b1);
        m_force = 1'b1;
    endtask

    // Random writeback order plus random injections; a start while busy is slipped in.
    task automatic force_random();
        int p[4];
        int t;
        int j;
        for (int i = 0; i < 4; i++) p[i] = i;
        for (int i = 3; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = p[i]; p[i] = p[j]; p[j] = t;
        end
        for (int i = 0; i < 4; i++) begin
            ref_wb_issued = 4'(1 << p[i]);
            pkt_injected  = 4'($urandom_range(0, 15));
            if (m_cnt + $countones(pkt_injected) > CMX) pkt_injected = 4'h0;
            if (i == 1) begin
                start = 1'b1; num_iter = 8'd9;
            end
            tick();
            start = 1'b0;
        end
        ref_wb_issued = 4'h0;
        pkt_injected  = 4'h0;
        tick();
        chk1("all_ref_set", all_ref_wb_issued, 1'b1);
        goto_next_ref = 1'b1;
        tick();
        goto_next_ref = 1'b0;
        chk1("all_ref_cleared", all_ref_wb_issued, 1'b0);
    endtask

    task automatic to_drain();
        all_reading_done = 1'b1;
        tick();
        all_reading_done = 1'b0;
        m_force = 1'b0;
        m_drain = 1'b1;
    endtask

    task automatic drain_to_zero();
        int guard = 0;
        while (m_cnt > 0 && guard < 64) begin
            pkt_delivered = (m_cnt >= 4) ? 4'hF : 4'((1 << m_cnt) - 1);
            tick();
            chk1("drain_hold_mus", motion_update_start, 1'b0);
            guard++;
        end
        pkt_delivered = 4'h0;
        chk1("drain_bounded", m_cnt == 0, 1'b1);
    endtask

    task automatic mu_transition();
        tick();
        m_drain = 1'b0;
        chk1("mus_pulse", motion_update_start, 1'b1);
        chk1("mus_busy", busy, 1'b1);
        tick();
        chk1("mus_pulse_end", motion_update_start, 1'b0);
    endtask

    task automatic finish_mu(input bit last, input int exp_count);
        for (int i = 0; i < 2; i++) begin
            tick();
            chkn("mu_wait_count", 32'(iter_count), 32'(exp_count - 1));
        end
        mu_done = 1'b1;
        tick();
        mu_done = 1'b0;
        chkn("iter_count", 32'(iter_count), 32'(exp_count));
        if (last) begin
            chk1("finish_done", done, 1'b1);
            chk1("finish_no_iter_start", iter_start, 1'b0);
            chk1("finish_busy", busy, 1'b1);
            tick();
            chk1("finish_done_pulse", done, 1'b0);
            chk1("finish_idle_busy", busy, 1'b0);
`ifdef ITER_SEQ_PERF_CNT_EN
            chkn("force_cycles", force_cycles, 32'(m_fc));
            chkn("drain_cycles", drain_cycles, 32'(m_dc));
`endif
        end else begin
            chk1("relaunch_iter_start", iter_start, 1'b1);
            chk1("relaunch_done", done, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_iter = '0; ref_wb_issued = '0; goto_next_ref = 1'b0;
        pkt_injected = '0; pkt_delivered = '0; all_reading_done = 1'b0;
        all_filter_buffer_empty = 1'b1; force_cache_input_buffer_empty = 1'b1; mu_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_iter_start", iter_start, 1'b0);
        chk1("rst_mus", motion_update_start, 1'b0);
        chkn("rst_iter_count", 32'(iter_count), 32'd0);

        // Two full iterations with random handshakes
        start_run(2);
        for (int k = 1; k <= 2; k++) begin
            enter_force();
            force_random();
            to_drain();
            drain_to_zero();
            mu_transition();
            finish_mu(k == 2, k);
        end

        // Writeback bits one per cycle, then a bit coinciding with goto_next_ref
        start_run(1);
        enter_force();
        for (int b = 0; b < 4; b++) begin
            ref_wb_issued = 4'(1 << b);
            tick();
            chk1("wb_seq_low", all_ref_wb_issued, 1'b0);
        end
        ref_wb_issued = 4'h0;
        tick();
        chk1("wb_seq_rise", all_ref_wb_issued, 1'b1);
        goto_next_ref = 1'b1;
        tick();
        goto_next_ref = 1'b0;
        chk1("wb_seq_clear", all_ref_wb_issued, 1'b0);
        ref_wb_issued = 4'b0111;
        tick();
        ref_wb_issued = 4'b0001;
        goto_next_ref = 1'b1;
        tick();
        goto_next_ref = 1'b0;
        ref_wb_issued = 4'b1110;
        tick();
        ref_wb_issued = 4'h0;
        tick();
        chk1("wb_same_cycle_kept", all_ref_wb_issued, 1'b1);
        goto_next_ref = 1'b1;
        tick();
        goto_next_ref = 1'b0;
        to_drain();
        drain_to_zero();
        mu_transition();
        finish_mu(1'b1, 1);

        // Three injections on node 0, two deliveries: drain must hold until the third
        start_run(1);
        enter_force();
        pkt_injected = 4'b0001;
        for (int i = 0; i < 3; i++) tick();
        pkt_injected  = 4'h0;
        pkt_delivered = 4'b0001;
        for (int i = 0; i < 2; i++) tick();
        pkt_delivered = 4'h0;
        chkn("s3_count_one", 32'(dut.w_inflight_count), 32'd1);
        to_drain();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("s3_drain_hold", motion_update_start, 1'b0);
            chk1("s3_drain_busy", busy, 1'b1);
        end
        pkt_delivered = 4'b0001;
        tick();
        pkt_delivered = 4'h0;
        chk1("s3_no_mus_yet", motion_update_start, 1'b0);
        mu_transition();
        finish_mu(1'b1, 1);

        // Simultaneous inject/deliver, underflow, overflow, and each drain-exit blocker
        start_run(1);
        enter_force();
        pkt_injected = 4'b1111; pkt_delivered = 4'b0011;
        tick();
        chkn("s4_plus_two", 32'(dut.w_inflight_count), 32'd2);
        pkt_injected = 4'h0;
        tick();
        chkn("s4_back_zero", 32'(dut.w_inflight_count), 32'd0);
        pkt_delivered = 4'b0001;
        tick();
        pkt_delivered = 4'h0;
        chkn("s4_underflow_zero", 32'(dut.w_inflight_count), 32'd0);
        chk1("s4_underflow_err", overflow_err, 1'b1);
        pkt_injected = 4'hF;
        for (int i = 0; i < 4; i++) tick();
        pkt_injected = 4'h0;
        chkn("s4_overflow_sat", 32'(dut.w_inflight_count), 32'(CMX));
        to_drain();
        drain_to_zero();
        all_filter_buffer_empty = 1'b0;
        tick();
        chk1("s4_block_filter", motion_update_start, 1'b0);
        all_filter_buffer_empty = 1'b1;
        force_cache_input_buffer_empty = 1'b0;
        tick();
        chk1("s4_block_fcib", motion_update_start, 1'b0);
        force_cache_input_buffer_empty = 1'b1;
        pkt_injected = 4'b0010; pkt_delivered = 4'b0010;
        tick();
        chk1("s4_block_inject", motion_update_start, 1'b0);
        pkt_injected = 4'h0; pkt_delivered = 4'h0;
        mu_transition();
        finish_mu(1'b1, 1);

        // Reset in DRAIN aborts the run silently; a fresh run then works
        start_run(1);
        enter_force();
        pkt_injected = 4'b0011;
        tick();
        pkt_injected = 4'h0;
        to_drain();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_force = 1'b0; m_drain = 1'b0;
        chk1("s5_busy", busy, 1'b0);
        chk1("s5_done", done, 1'b0);
        chk1("s5_iter_start", iter_start, 1'b0);
        chk1("s5_mus", motion_update_start, 1'b0);
        chkn("s5_iter_count", 32'(iter_count), 32'd0);
`ifdef ITER_SEQ_PERF_CNT_EN
        chkn("s5_force_cycles", force_cycles, 32'd0);
        chkn("s5_drain_cycles", drain_cycles, 32'd0);
`endif
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1("s5_no_done", done, 1'b0);
            chk1("s5_idle", busy, 1'b0);
        end
        start_run(1);
        enter_force();
        force_random();
        to_drain();
        drain_to_zero();
        mu_transition();
        finish_mu(1'b1, 1);

        // Zero iterations: immediate done, no launch
        start_run(0);
`ifdef ITER_SEQ_PERF_CNT_EN
        chkn("s6_force_cycles", force_cycles, 32'(m_fc));
`endif
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("s6_no_iter_start", iter_start, 1'b0);
            chk1("s6_idle", busy, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
